// File: rtl/display_spi_pkg.sv
// Shared definitions for the display SPI command path: opcodes and sequencer states.
// Pure declarations, no logic or latency of its own.
// Imported by the command sequencer and by host-side models / future read-back logic.
package display_spi_pkg;

    // Opcodes carried in the first byte of each select window.
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_BRIGHT = 8'h02;
    localparam logic [7:0] CMD_SWAP   = 8'h03;
    localparam logic [7:0] CMD_CTRL   = 8'h04;

    // Command sequencer states.
    typedef enum logic [2:0] {
        ST_CMD        = 3'd0,
        ST_ADDR_HI    = 3'd1,
        ST_ADDR_LO    = 3'd2,
        ST_DATA       = 3'd3,
        ST_ARG_BRIGHT = 3'd4,
        ST_ARG_CTRL   = 3'd5,
        ST_DISCARD    = 3'd6
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Decodes the spi_slave byte stream of one select window into framebuffer writes, swap and control registers.
// Latency: every output is registered and reflects an accepted byte one clk later.
// No backpressure: a byte may arrive every cycle; bytes with ss low are dropped and the window restarts.
module spi_cmd_ctrl
    import display_spi_pkg::*;
#(
    parameter int         ADDR_WIDTH   = 11,
    parameter logic [7:0] BRIGHT_RESET = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  swap,
    output logic [7:0]            brightness,
    output logic                  enable,
    output logic [7:0]            err_count
);

    state_t                state_q, state_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    // Address of the next DATA byte; separate from wr_addr so wr_addr holds between writes.
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [7:0]            wr_data_d;
    logic                  swap_d;
    logic [7:0]            bright_d;
    logic                  enable_d;
    logic [7:0]            err_d;
    logic [15:0]           full_addr;

    assign full_addr = {addr_hi_q, rx_data};

    // Next-state and output decode; ss low always returns to CMD and accepts nothing.
    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        swap_d    = 1'b0;
        bright_d  = brightness;
        enable_d  = enable;
        err_d     = err_count;

        if (!ss) begin
            state_d = ST_CMD;
        end else if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
                    case (rx_data)
                        CMD_WRITE:  state_d = ST_ADDR_HI;
                        CMD_BRIGHT: state_d = ST_ARG_BRIGHT;
                        CMD_CTRL:   state_d = ST_ARG_CTRL;
                        CMD_SWAP: begin
                            swap_d  = 1'b1;
                            state_d = ST_DISCARD;
                        end
                        default: begin
                            err_d   = sat_inc8(err_count);
                            state_d = ST_DISCARD;
                        end
                    endcase
                end
                ST_ADDR_HI: begin
                    addr_hi_d = rx_data;
                    state_d   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    // Host sends a 16-bit address; only the low ADDR_WIDTH bits are meaningful.
                    ptr_d   = ADDR_WIDTH'(full_addr);
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = rx_data;
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
                end
                ST_ARG_BRIGHT: begin
                    bright_d = rx_data;
                    state_d  = ST_DISCARD;
                end
                ST_ARG_CTRL: begin
                    enable_d = rx_data[0];
                    state_d  = ST_DISCARD;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, address working registers and all outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CMD;
            addr_hi_q  <= 8'h00;
            ptr_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            swap       <= 1'b0;
            brightness <= BRIGHT_RESET;
            enable     <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_hi_q  <= addr_hi_d;
            ptr_q      <= ptr_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            swap       <= swap_d;
            brightness <= bright_d;
            enable     <= enable_d;
            err_count  <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: window-level reference model feeding write/swap scoreboards.
// Directed windows from the command set plus randomized windows, gaps and stray bytes.
// Registers are compared after each window; writes/swaps are compared by a separate monitor.
module tb_spi_cmd_ctrl;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          ss;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          swap;
    logic [7:0]    brightness;
    logic          enable;
    logic [7:0]    err_count;

    spi_cmd_ctrl #(.ADDR_WIDTH(AW), .BRIGHT_RESET(8'h80)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap       (swap),
        .brightness (brightness),
        .enable     (enable),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t wq[$];
    int  sq[$];

    int total = 0;
    int bad   = 0;

    // Reference model state, expressed per window: byte index k and the bytes seen so far.
    int            k;
    logic [7:0]    op, hi, lo;
    logic [7:0]    m_bright;
    logic          m_en;
    int            m_err;
    logic [AW-1:0] m_last_addr;
    logic [7:0]    m_last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        k = 0; op = 0; hi = 0; lo = 0;
        m_bright = 8'h80; m_en = 1'b0; m_err = 0;
        m_last_addr = '0; m_last_data = 8'h00;
    endtask

    // Effect of the k-th accepted byte of a window, seen at the next clock.
    task automatic model_byte(input logic [7:0] v);
        int full;
        wr_t w;
        if (k == 0) begin
            op = v;
            if (v == 8'h03) sq.push_back(cyc + 1);
            else if (!(v == 8'h01 || v == 8'h02 || v == 8'h04)) m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (op == 8'h01) begin
            if (k == 1) hi = v;
            else if (k == 2) lo = v;
            else begin
                full   = {16'd0, hi, lo};
                w.cyc  = cyc + 1;
                w.addr = AW'((full + k - 3) % (1 << AW));
                w.data = v;
                m_last_addr = w.addr;
                m_last_data = v;
                wq.push_back(w);
            end
        end else if (op == 8'h02 && k == 1) begin
            m_bright = v;
        end else if (op == 8'h04 && k == 1) begin
            m_en = v[0];
        end
        k++;
    endtask

    // One byte inside the window, followed by `gap` idle cycles (gap 0 = back-to-back).
    task automatic send(input logic [7:0] v, input int gap);
        @(posedge clk); #1;
        ss = 1'b1; rx_valid = 1'b1; rx_data = v;
        model_byte(v);
        repeat (gap) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic end_window();
        @(posedge clk); #1;
        rx_valid = 1'b0; ss = 1'b0;
        k = 0;
    endtask

    // Byte strobed with ss low: must be ignored and leave the sequencer in CMD.
    task automatic noss_byte(input logic [7:0] v);
        @(posedge clk); #1;
        ss = 1'b0; rx_valid = 1'b1; rx_data = v;
        k = 0;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic window(input logic [7:0] b[$], input int gap);
        foreach (b[i]) send(b[i], gap);
        end_window();
    endtask

    task automatic check_regs(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_bright"}, 32'(brightness), 32'(m_bright));
        check({tag, "_enable"}, 32'(enable), 32'(m_en));
        check({tag, "_err"}, 32'(err_count), 32'(m_err));
    endtask

    // Monitor: every write or swap the DUT presents must match the head of its scoreboard.
    always @(negedge clk) begin
        wr_t w;
        int  s;
        if (wr_en) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required none (cycle %0d)", wr_addr, wr_data, cyc);
            end else begin
                w = wq.pop_front();
                check("wr_cycle", 32'(cyc), 32'(w.cyc));
                check("wr_addr", 32'(wr_addr), 32'(w.addr));
                check("wr_data", 32'(wr_data), 32'(w.data));
            end
        end
        if (swap) begin
            if (sq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_swap actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                s = sq.pop_front();
                check("swap_cycle", 32'(cyc), 32'(s));
            end
        end
    end

    initial begin
        logic [7:0] b[$];
        int         len, sel;

        rst = 1'b1; ss = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_bright", 32'(brightness), 32'h80);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_err", 32'(err_count), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_swap", 32'(swap), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);

        // Basic write burst, bytes back-to-back.
        b = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        window(b, 0);
        // Address wrap, spaced bytes.
        b = '{8'h01, 8'h07, 8'hFF, 8'h11, 8'h22};
        window(b, 2);
        // Truncation of a 16-bit address.
        b = '{8'h01, 8'hFF, 8'hFF, 8'h33};
        window(b, 1);
        repeat (3) @(posedge clk);
        #1;
        check("wr_addr_hold", 32'(wr_addr), 32'(m_last_addr));
        check("wr_data_hold", 32'(wr_data), 32'(m_last_data));

        // Register commands with trailing extra bytes.
        b = '{8'h02, 8'h3C, 8'h99};
        window(b, 1);
        b = '{8'h04, 8'h03, 8'h00};
        window(b, 0);
        b = '{8'h03, 8'h03, 8'h02};
        window(b, 0);
        check_regs("regs");

        // Abort in ADDR_LO, stray bytes with ss low, then a fresh command.
        b = '{8'h01, 8'h00};
        window(b, 0);
        noss_byte(8'h03);
        noss_byte(8'h02);
        b = '{8'h02, 8'h55};
        window(b, 0);
        check_regs("abort");

        // Unknown opcodes until the counter saturates.
        b = '{8'h7E};
        repeat (300) window(b, 0);
        check_regs("err_sat");

        // Randomized windows.
        repeat (200) begin
            sel = $urandom_range(0, 5);
            b.delete();
            case (sel)
                0: b.push_back(8'h01);
                1: b.push_back(8'h02);
                2: b.push_back(8'h03);
                3: b.push_back(8'h04);
                default: b.push_back(8'($urandom_range(0, 255)));
            endcase
            len = $urandom_range(0, 7);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
            foreach (b[i]) send(b[i], $urandom_range(0, 3));
            end_window();
            if ($urandom_range(0, 3) == 0) noss_byte(8'($urandom_range(0, 255)));
            check_regs("rand");
        end

        // Reset in the middle of a DATA stream, with a byte strobed in the reset cycle.
        b = '{8'h01, 8'h01, 8'h00, 8'hA1, 8'hA2};
        foreach (b[i]) send(b[i], 0);
        @(posedge clk); #1;
        rst = 1'b1; ss = 1'b1; rx_valid = 1'b1; rx_data = 8'hA3;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        check("rst2_wr_en", 32'(wr_en), 32'h0);
        check("rst2_wr_addr", 32'(wr_addr), 32'h0);
        check("rst2_bright", 32'(brightness), 32'h80);
        // ss still high: the next byte must be taken as an opcode.
        send(8'h02, 0);
        send(8'h77, 0);
        end_window();
        check_regs("post_rst");

        repeat (4) @(posedge clk);
        #1;
        check("wq_drained", 32'(wq.size()), 32'h0);
        check("sq_drained", 32'(sq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
